// File: rtl/srl_cam.sv
// rtl/srl_cam.sv - SRL-style CAM: one-cycle registered lookup, multi-cycle shift-in write/delete.
// Each key slice is one-hot encoded into a 2**SLICE_WIDTH-bit shift register per entry.
module srl_cam #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_delete,
  input  logic                     write_enable,
  output logic                     write_busy,
  input  logic [DATA_WIDTH-1:0]    compare_data,
  output logic [2**ADDR_WIDTH-1:0] match_many,
  output logic [2**ADDR_WIDTH-1:0] match_single,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic                     match
);

  localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int PAD_WIDTH   = SLICE_COUNT * SLICE_WIDTH;
  localparam int DEPTH       = 2**SLICE_WIDTH;
  localparam int ENTRIES     = 2**ADDR_WIDTH;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [PAD_WIDTH-1:0]   data_q, data_d;
  logic                   delete_q, delete_d;
  logic [SLICE_WIDTH-1:0] count_q, count_d;

  logic [ENTRIES-1:0]     match_many_q, match_many_d;
  logic [ENTRIES-1:0]     match_single_q, match_single_d;
  logic [ADDR_WIDTH-1:0]  match_addr_q, match_addr_d;
  logic                   match_q, match_d;

  // Storage is deliberately not reset; it powers up as all-zero (every entry invalid).
  logic [DEPTH-1:0]       srl_q [SLICE_COUNT][ENTRIES];
  logic [DEPTH-1:0]       srl_d [SLICE_COUNT][ENTRIES];

  logic [PAD_WIDTH-1:0]   cmp_pad;
  logic [ENTRIES-1:0]     raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      delete_q       <= 1'b0;
      count_q        <= '0;
      match_many_q   <= '0;
      match_single_q <= '0;
      match_addr_q   <= '0;
      match_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      delete_q       <= delete_d;
      count_q        <= count_d;
      match_many_q   <= match_many_d;
      match_single_q <= match_single_d;
      match_addr_q   <= match_addr_d;
      match_q        <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    delete_d = delete_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (write_enable) begin
          state_d  = WRITE;
          addr_d   = write_addr;
          data_d   = PAD_WIDTH'(write_data);
          delete_d = write_delete;
          count_d  = '1;
        end
      end
      WRITE: begin
        count_d = count_q - SLICE_WIDTH'(1);
        if (count_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_busy = (state_q == WRITE);
  end

  // The bit entering at count c ends up at position c after the remaining shifts.
  always_comb begin
    srl_d = srl_q;
    if (state_q == WRITE) begin
      for (int s = 0; s < SLICE_COUNT; s++) begin
        srl_d[s][addr_q] = {srl_q[s][addr_q][DEPTH-2:0],
                            (data_q[s*SLICE_WIDTH +: SLICE_WIDTH] == count_q) & ~delete_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    srl_q <= srl_d;
  end

  always_comb begin
    cmp_pad = PAD_WIDTH'(compare_data);
    raw     = '1;
    for (int e = 0; e < ENTRIES; e++) begin
      for (int s = 0; s < SLICE_COUNT; s++) begin
        raw[e] = raw[e] & srl_q[s][e][cmp_pad[s*SLICE_WIDTH +: SLICE_WIDTH]];
      end
    end
  end

  always_comb begin
    match_many_d   = raw;
    match_single_d = '0;
    match_addr_d   = '0;
    match_d        = |raw;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (raw[e]) begin
        match_single_d    = '0;
        match_single_d[e] = 1'b1;
        match_addr_d      = ADDR_WIDTH'(e);
      end
    end
  end

  assign match_many   = match_many_q;
  assign match_single = match_single_q;
  assign match_addr   = match_addr_q;
  assign match        = match_q;

endmodule

// File: tb/tb_srl_cam.sv
// tb/tb_srl_cam.sv - directed table-driven bench for srl_cam.
module tb_srl_cam;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [63:0] write_data = '0;
  logic        write_delete = 1'b0;
  logic        write_enable = 1'b0;
  logic        write_busy;
  logic [63:0] compare_data = '0;
  logic [31:0] match_many;
  logic [31:0] match_single;
  logic [4:0]  match_addr;
  logic        match;

  int passed = 0;
  int total  = 0;

  localparam logic [63:0] K = 64'h0123456789ABCDEF;

  srl_cam #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .SLICE_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_delete (write_delete),
    .write_enable (write_enable),
    .write_busy   (write_busy),
    .compare_data (compare_data),
    .match_many   (match_many),
    .match_single (match_single),
    .match_addr   (match_addr),
    .match        (match)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_wr;
    bit          del;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] cmp;
    logic [31:0] exp_many;
    logic [31:0] exp_single;
    logic [4:0]  exp_addr;
    logic        exp_match;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic del,
                          output int len);
    write_addr   = a;
    write_data   = d;
    write_delete = del;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    len = 0;
    while (write_busy && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic chk_outs(input string name, input logic [31:0] many, input logic [31:0] single,
                          input logic [4:0] addr, input logic m);
    chk({name, "_many"},   64'(match_many),   64'(many));
    chk({name, "_single"}, 64'(match_single), 64'(single));
    chk({name, "_addr"},   64'(match_addr),   64'(addr));
    chk({name, "_match"},  64'(match),        64'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    logic [63:0] pkeys [4];
    logic [31:0] pexp  [4];

    //         wr    del   waddr wdata            cmp                    many          single        addr  m
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  64'h0,         K,                     32'h0,        32'h0,        5'd0, 1'b0, "powerup"};
    vecs[1]  = '{1'b1, 1'b0, 5'd1,  K,             K,                     32'h2,        32'h2,        5'd1, 1'b1, "wr1"};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  64'h0,         K ^ 64'h1,             32'h0,        32'h0,        5'd0, 1'b0, "bitflip"};
    vecs[3]  = '{1'b1, 1'b0, 5'd5,  K,             K,                     32'h22,       32'h2,        5'd1, 1'b1, "wr5"};
    vecs[4]  = '{1'b1, 1'b0, 5'd3,  K,             K,                     32'h2A,       32'h2,        5'd1, 1'b1, "wr3"};
    vecs[5]  = '{1'b1, 1'b1, 5'd1,  64'hFFFF,      K,                     32'h28,       32'h8,        5'd3, 1'b1, "del1"};
    vecs[6]  = '{1'b1, 1'b0, 5'd3,  64'h1111,      K,                     32'h20,       32'h20,       5'd5, 1'b1, "ovr3"};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,         64'h1111,              32'h8,        32'h8,        5'd3, 1'b1, "new3"};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  64'h0,         64'h0,                 32'h1,        32'h1,        5'd0, 1'b1, "zerokey"};
    vecs[9]  = '{1'b1, 1'b0, 5'd31, K,             K,                     32'h80000020, 32'h20,       5'd5, 1'b1, "wr31"};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  64'h0,         64'hFFFFFFFFFFFFFFFF,  32'h0,        32'h0,        5'd0, 1'b0, "allones"};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(write_busy), 64'h0);
    chk_outs("rst", 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) begin
        do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].del, len);
        chk({vecs[i].name, "_busylen"}, 64'(len), 64'd16);
      end
      compare_data = vecs[i].cmp;
      @(negedge clk);
      chk_outs(vecs[i].name, vecs[i].exp_many, vecs[i].exp_single, vecs[i].exp_addr, vecs[i].exp_match);
    end

    // One-cycle compare latency, then a new key every cycle
    compare_data = 64'h1111;
    #1;
    chk("lat_before", 64'(match), 64'h0);
    @(negedge clk);
    chk("lat_after", 64'(match_many), 64'h8);
    pkeys = '{K, 64'h1111, 64'hDEAD, 64'h0};
    pexp  = '{32'h80000020, 32'h8, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      compare_data = pkeys[i];
      @(negedge clk);
      chk("pipe_many", 64'(match_many), 64'(pexp[i]));
    end

    // Write with an ignored enable pulse while a lookup of another entry keeps hitting
    compare_data = 64'h1111;
    @(negedge clk);
    write_addr   = 5'd10;
    write_data   = 64'hABCD;
    write_delete = 1'b0;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    len = 0;
    while (write_busy && len < 100) begin
      chk("hold_match", 64'(match), 64'h1);
      chk("hold_bit3", 64'(match_many[3]), 64'h1);
      if (len == 4) begin
        write_addr   = 5'd7;
        write_data   = 64'h1111;
        write_enable = 1'b1;
      end
      if (len == 5) write_enable = 1'b0;
      len++;
      @(negedge clk);
    end
    chk("ign_busylen", 64'(len), 64'd16);
    compare_data = 64'h1111;
    @(negedge clk);
    chk("ign_noqueue", 64'(write_busy), 64'h0);
    chk("ign_many", 64'(match_many), 64'h8);
    compare_data = 64'hABCD;
    @(negedge clk);
    chk_outs("wr10", 32'h400, 32'h400, 5'd10, 1'b1);

    // Reset in the middle of a write
    write_addr   = 5'd12;
    write_data   = 64'h5555;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_pre", 64'(write_busy), 64'h1);
    rst = 1'b0;
    #1;
    chk("mid_busy", 64'(write_busy), 64'h0);
    chk_outs("mid_rst", 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_write(5'd12, 64'h7777, 1'b0, len);
    chk("post_busylen", 64'(len), 64'd16);
    compare_data = 64'h7777;
    @(negedge clk);
    chk_outs("post12", 32'h1000, 32'h1000, 5'd12, 1'b1);
    compare_data = 64'hABCD;
    @(negedge clk);
    chk("post10_many", 64'(match_many), 64'h400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/srl_cam.md
Name: srl_cam

Overview:
- Content-addressable memory built from shift-register (SRL-style) storage, with 2**ADDR_WIDTH entries of DATA_WIDTH bits.
- A lookup takes one cycle: it compares compare_data against all entries and returns a match bit-vector plus a priority-encoded hit address.
- A write or delete runs over several cycles, one shift per cycle, while write_busy is high.
- Used as the MAC lookup table in the L2 switch.

Parameters:
- DATA_WIDTH, 64, key width in bits.
- ADDR_WIDTH, 5, log2 of entry count (32 entries).
- SLICE_WIDTH, 4, key bits per storage slice. Each slice's shift registers are 2**SLICE_WIDTH deep, so a write takes 2**SLICE_WIDTH cycles.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- write_addr  in  ADDR_WIDTH  entry index to write or delete.
- write_data  in  DATA_WIDTH  key to store.
- write_delete  in  1  1 = invalidate the entry; write_data is ignored.
- write_enable  in  1  write request; sampled only when write_busy=0.
- write_busy  out  1  high while a write/delete is in progress.
- compare_data  in  DATA_WIDTH  lookup key.
- match_many  out  2**ADDR_WIDTH  bit i = entry i matches.
- match_single  out  2**ADDR_WIDTH  one-hot of the lowest-index match; 0 if no match.
- match_addr  out  ADDR_WIDTH  index of the lowest-index match; 0 if no match.
- match  out  1  OR of match_many.

Behaviour:
- Slicing:
  - SLICE_COUNT = ceil(DATA_WIDTH/SLICE_WIDTH).
  - Keys are zero-padded at the MSB to SLICE_COUNT*SLICE_WIDTH bits, for both writes and compares.
  - Slice s is key bits [s*SLICE_WIDTH +: SLICE_WIDTH].
- Storage:
  - For each slice s and entry e there is a 2**SLICE_WIDTH-bit shift register srl[s][e].
  - Bit v of srl[s][e] is 1 iff entry e is valid and its slice s equals v.
- Compare:
  - raw[e] = AND over s of srl[s][e][compare_data slice s].
  - All four match outputs are registered: 1-cycle latency from compare_data.
  - Matching is fully pipelined; one new key can be applied every cycle.
- Write state machine, states IDLE and WRITE:
  - IDLE with write_enable=1: latch write_addr, write_data and write_delete; load count = 2**SLICE_WIDTH-1; go to WRITE. write_busy goes high on the next edge.
  - WRITE, each cycle: for every slice s, shift srl[s][addr] left by one. The bit shifted into bit 0 is (count == data slice s) & ~delete.
  - WRITE, count decrement: count decrements by 1 each cycle.
  - WRITE, exit: after the shift with count=0, return to IDLE and drop write_busy. The operation therefore spans exactly 2**SLICE_WIDTH cycles of busy.
  - Only the addressed entry shifts; other entries hold.
- Visibility and overlap rules:
  - Lookups of other entries stay valid during a write.
  - Match results for the entry under write are undefined while busy.
  - The new contents are visible to a compare applied in the first cycle after write_busy falls.
  - write_enable is ignored while busy. Requests are not queued; the requester must hold or retry.
  - Writing an already-valid entry overwrites it; no delete is needed first.
  - Identical keys in several entries are legal: match_many shows all of them; match_addr/match_single report the lowest index.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and write_busy=0.
  - match_many, match_single, match_addr and match go to 0.
  - An in-progress write is abandoned; that entry's contents are undefined until rewritten.
- Storage contents are not cleared by reset. They are initialized to 0 (all entries invalid) at configuration or power-up.
- The all-zero key is storable like any other key.

Test Plan:
- Power-up with no writes, compare any key -> match=0, match_many=0, match_addr=0.
- Write addr 1, data 0x0123456789ABCDEF -> write_busy high for exactly 16 cycles. Compare the same key afterwards -> match_many=0x00000002, match_addr=1, match_single=0x2, match=1. Compare with one bit flipped -> match=0.
- Write the same key to entries 5 and 3 -> match_many=0x0000002A, match_addr=1. After deleting entry 1 -> match_many=0x00000028, match_addr=3, match_single=0x8.
- Overwrite entry 3 with 0x1111 -> the old key no longer hits entry 3. 0x1111 hits entry 3, with 1-cycle compare latency.
- Pulse write_enable during busy -> ignored, with no effect on storage. A continuous compare on another entry stays at match=1 throughout the write.
- Assert rst mid-write -> write_busy=0 and match outputs=0 immediately. A subsequent write completes normally.
